bram_ctrl: RTL
==============

Name: bram_ctrl

Overview:
- Parametrised successor to the MCU single-port block RAM.
- Adds a valid/ready request channel, byte-lane write strobes, selectable read latency (1 or 2), out-of-range detection and a synthesizable post-reset clear sweep that replaces whole-array reset.
- Sits between the CPU load/store unit and on-chip RAM.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 16384, number of words.
- ADDR_W, 16, word-address width; requires 2^ADDR_W >= DEPTH.
- RD_LATENCY, 1, accepted read to rsp_valid in cycles; legal values are 1 and 2.
- CLEAR_ON_RESET, 1, when 1, memory is zero-filled after reset.
- CLEAR_VAL, 0, DATA_W-bit value written by the clear sweep.

Ports:
- clk, input, 1, clock; all activity on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, block can accept a request this cycle.
- req_we, input, 1, 1 = write, 0 = read.
- req_be, input, DATA_W/8, byte-lane write enables; bit i covers data bits [8i+7:8i].
- req_addr, input, ADDR_W, word address.
- req_wdata, input, DATA_W, write data.
- rsp_valid, output, 1, one-cycle pulse carrying read data.
- rsp_rdata, output, DATA_W, read data; valid only while rsp_valid is high.
- rsp_err, output, 1, read address was out of range; valid only while rsp_valid is high.
- busy, output, 1, clear sweep in progress.

Behaviour:
- Reset (rst low, asynchronous): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. Clear counter goes to 0. Read pipeline is flushed. Memory array is not reset asynchronously.
- State machine, state set during reset: CLEAR if CLEAR_ON_RESET=1, else RUN.
- CLEAR state:
  - busy=1 from the first edge after rst rises; req_ready=0.
  - Writes CLEAR_VAL to address cnt on each edge; cnt increments.
  - After address DEPTH-1 is written, goes to RUN; busy=0 and req_ready=1 on the next cycle.
  - Sweep takes exactly DEPTH cycles.
- RUN state: req_ready=1 constantly. A request is accepted on an edge where req_valid and req_ready are both 1. One request per cycle; back-to-back accepts allowed.
- Write (req_we=1):
  - Each byte lane with req_be[i]=1 is updated on the accept edge; lanes with req_be[i]=0 keep their value.
  - req_be=0 is a legal no-op.
  - No response is generated.
- Read (req_we=0): array is sampled on the accept edge.
  - RD_LATENCY=1: rsp_valid is high in the cycle after the accept edge.
  - RD_LATENCY=2: an extra output register adds one cycle.
  - Pipelined reads keep issue order; no bubbles are inserted.
- Read-after-write to the same address in consecutive cycles returns the new data; the write has committed before the read samples.
- Out of range (req_addr >= DEPTH):
  - Write: ignored; memory is unchanged.
  - Read: returns rsp_rdata=0 and rsp_err=1 at the normal latency.
  - In-range reads return rsp_err=0.
- Requests with req_valid=1 while req_ready=0 are not accepted; the requester holds them.
- Reset asserted mid-sweep or mid-read: in-flight responses are discarded, with no rsp_valid after release. Sweep restarts from address 0.
- rsp_rdata and rsp_err return to 0 in every cycle where rsp_valid=0.

Test Plan:
- Reset and clear with DEPTH=16, CLEAR_ON_RESET=1:
  - Release rst -> busy=1 for 16 cycles, then req_ready=1.
  - Reads of addresses 0..15 all return 0x00000000 with rsp_err=0.
- Byte strobes:
  - Write 0xAABBCCDD to address 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
  - Read address 5 -> 0xAA22CC44 one cycle later (RD_LATENCY=1).
- Back-to-back with RD_LATENCY=2:
  - Cycle 0 write 0xDEADBEEF to address 3; cycles 1, 2, 3 read addresses 3, 4, 3.
  - rsp_valid is high in cycles 3, 4, 5 with data 0xDEADBEEF, 0, 0xDEADBEEF.
- Out of range with DEPTH=16:
  - Write 0x12345678 to address 20 -> no memory change.
  - Read address 20 -> rsp_rdata=0, rsp_err=1; read address 4 -> rsp_err=0.
- Reset mid-operation:
  - Assert rst at sweep count 7 -> busy=0 immediately.
  - On release the sweep restarts and takes 16 more cycles.
  - A read accepted before a reset pulse produces no rsp_valid.
- CLEAR_ON_RESET=0: req_ready=1 on the first edge after rst release; busy is never asserted.

Source files
------------

// File: rtl/bram_ctrl.sv
// Single-port block RAM controller: valid/ready request channel, byte-lane writes,
// 1- or 2-cycle read latency, out-of-range detection and a post-reset clear sweep.
module bram_ctrl #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 16384,
  parameter int unsigned       ADDR_W         = 16,
  parameter int unsigned       RD_LATENCY     = 1,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  localparam logic [0:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [MEM_AW-1:0] cnt;
  logic [MEM_AW-1:0] cnt_nxt;
  logic              busy_nxt;
  logic              ready_nxt;

  logic              accept;
  logic              in_range;
  logic              sweep_we;
  logic              last;
  logic [MEM_AW-1:0] mem_idx;

  logic              rd_vld;
  logic              rd_err;
  logic [DATA_W-1:0] rd_data;

  assign accept   = req_valid && req_ready;
  // Compare one bit wider so DEPTH == 2**ADDR_W does not wrap to zero.
  assign in_range = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign mem_idx  = req_addr[MEM_AW-1:0];
  // The sweep writes during cycles in which busy is high, giving exactly DEPTH busy cycles.
  assign sweep_we = (state == S_CLEAR) && busy;
  assign last     = (cnt == MEM_AW'(DEPTH - 1));

  // State and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RESET;
      cnt       <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      req_ready <= ready_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = 1'b0;
    ready_nxt = 1'b0;
    case (state)
      S_CLEAR: begin
        busy_nxt = 1'b1;
        if (busy) begin
          cnt_nxt = cnt + MEM_AW'(1);
          if (last) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            ready_nxt = 1'b1;
          end
        end
      end
      default: begin
        ready_nxt = 1'b1;
      end
    endcase
  end

  // Array write port: clear sweep has priority, otherwise byte-lane writes
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt] <= CLEAR_VAL;
    end else if (accept && req_we && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem[mem_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // First read stage; data and error are forced to zero when no read is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld  <= 1'b0;
      rd_err  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld  <= accept && !req_we;
      rd_err  <= accept && !req_we && !in_range;
      rd_data <= (accept && !req_we && in_range) ? mem[mem_idx] : '0;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end else begin
          rsp_valid <= rd_vld;
          rsp_err   <= rd_err;
          rsp_rdata <= rd_data;
        end
      end
    end else begin : g_lat1
      assign rsp_valid = rd_vld;
      assign rsp_err   = rd_err;
      assign rsp_rdata = rd_data;
    end
  endgenerate

endmodule
